// File: rtl/node_link_pkg.sv
`default_nettype none
// ============================================================================
// Package     : node_link_pkg
// Description : Shared types for the node link adapter. Defines the packet
//               layout, the burst length and the TX serialiser states, plus a
//               helper that picks one wire-order byte out of a packet.
// Revision    : 1.0 - initial release
// ============================================================================
package node_link_pkg;

    typedef struct packed {
        logic [3:0]  src;
        logic [3:0]  dest;
        logic [23:0] data;
    } pkt_t;

    localparam int PKT_BYTES = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_e;

    // Wire order is most significant byte first: index 0 carries {src,dest}.
    function automatic logic [7:0] pkt_byte(input pkt_t pkt, input logic [1:0] idx);
        logic [31:0] word;
        word = pkt;
        case (idx)
            2'd0:    return word[31:24];
            2'd1:    return word[23:16];
            2'd2:    return word[15:8];
            default: return word[7:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/node_link_adapter_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pkt_fifo
// Description : First-word-fall-through synchronous FIFO. The head entry is
//               visible on 'head' whenever 'empty' is low. A push on a full
//               FIFO is accepted only when a pop happens in the same cycle.
// Ports       : clock, reset_n (async active-low), push/push_data,
//               pop, head, count, full, empty
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_depth = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth);

endmodule
`default_nettype wire

// File: rtl/node_link_adapter.sv
`default_nettype none
// ============================================================================
// Module      : node_link_adapter
// Description : Node-side endpoint of one router port.
//               TX: packet FIFO from the node, serialised as 4 bytes on
//                   put_out/payload_out whenever the router reports free_in.
//               RX: 4-byte bursts from the router reassembled into packets
//                   and buffered for the node; free_out reserves a slot for
//                   any burst already in progress.
// Ports       : clock, reset_n (async active-low)
//               tx_pkt/tx_valid/tx_ready       node -> adapter packets
//               free_in/put_out/payload_out    adapter -> router bytes
//               put_in/payload_in/free_out     router -> adapter bytes
//               rx_pkt/rx_valid/rx_ready       adapter -> node packets
//               rx_err (sticky), tx_src_mismatch (saturating counter)
// Revision    : 1.0 - initial release
// ============================================================================
module node_link_adapter
    import node_link_pkg::*;
#(
    parameter int NODEID   = 0,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  pkt_t        tx_pkt,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        free_in,
    output logic        put_out,
    output logic [7:0]  payload_out,
    input  logic        put_in,
    input  logic [7:0]  payload_in,
    output logic        free_out,
    output pkt_t        rx_pkt,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_err,
    output logic [7:0]  tx_src_mismatch
);
    localparam int TCW = $clog2(TX_DEPTH);
    localparam int RCW = $clog2(RX_DEPTH);
    localparam logic [3:0]     c_node_id   = NODEID[3:0];
    localparam logic [1:0]     c_last_byte = 2'(PKT_BYTES - 1);
    localparam logic [RCW+1:0] c_rx_limit  = RX_DEPTH[RCW+1:0];

    // ---------------------------------------------------------------- TX path
    logic         w_tx_push;
    logic         w_tx_pop;
    logic         w_tx_full;
    logic         w_tx_empty;
    pkt_t         w_tx_head;
    logic [TCW:0] w_tx_count;
    tx_state_e    r_tx_state;
    logic [1:0]   r_tx_byte;     // index of the next byte to launch
    logic         w_tx_boundary;
    logic         w_tx_start;

    assign tx_ready  = ~w_tx_full;
    assign w_tx_push = tx_valid & tx_ready;

    pkt_fifo #(.WIDTH(32), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (w_tx_push),
        .push_data (tx_pkt),
        .pop       (w_tx_pop),
        .head      (w_tx_head),
        .count     (w_tx_count),
        .full      (w_tx_full),
        .empty     (w_tx_empty)
    );

    // A packet boundary is either idle or the edge right after byte3 went out;
    // only there is free_in consulted, which gives gapless back-to-back bursts.
    assign w_tx_boundary = (r_tx_state == IDLE) || (r_tx_byte == 2'd0);
    assign w_tx_start    = ~w_tx_empty & free_in;
    assign w_tx_pop      = (r_tx_state == SEND) && (r_tx_byte == c_last_byte);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_state  <= IDLE;
            r_tx_byte   <= 2'd0;
            put_out     <= 1'b0;
            payload_out <= 8'h00;
        end else if (w_tx_boundary) begin
            if (w_tx_start) begin
                r_tx_state  <= SEND;
                r_tx_byte   <= 2'd1;
                put_out     <= 1'b1;
                payload_out <= pkt_byte(w_tx_head, 2'd0);
            end else begin
                r_tx_state  <= IDLE;
                r_tx_byte   <= 2'd0;
                put_out     <= 1'b0;
                payload_out <= 8'h00;
            end
        end else begin
            put_out     <= 1'b1;
            payload_out <= pkt_byte(w_tx_head, r_tx_byte);
            r_tx_byte   <= r_tx_byte + 2'd1;   // wraps to 0 after byte3
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tx_src_mismatch <= 8'h00;
        end else if (w_tx_push && (tx_pkt.src != c_node_id) && (tx_src_mismatch != 8'hFF)) begin
            tx_src_mismatch <= tx_src_mismatch + 8'd1;
        end
    end

    // ---------------------------------------------------------------- RX path
    logic         w_rx_push;
    logic         w_rx_pop;
    logic         w_rx_full;
    logic         w_rx_empty;
    logic [RCW:0] w_rx_count;
    logic [RCW+1:0] w_rx_used;
    pkt_t         w_rx_word;
    logic [1:0]   r_rx_byte;
    logic [23:0]  r_rx_asm;
    logic         r_rx_drop;     // ignoring the rest of a refused burst

    assign w_rx_word = {r_rx_asm, payload_in};
    assign w_rx_push = put_in & ~r_rx_drop & (r_rx_byte == c_last_byte);
    assign w_rx_pop  = rx_valid & rx_ready;
    assign rx_valid  = ~w_rx_empty;

    pkt_fifo #(.WIDTH(32), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (w_rx_push),
        .push_data (w_rx_word),
        .pop       (w_rx_pop),
        .head      (rx_pkt),
        .count     (w_rx_count),
        .full      (w_rx_full),
        .empty     (w_rx_empty)
    );

    // A burst in flight already owns a FIFO slot, so its final push can
    // never overflow even if the node does not pop.
    assign w_rx_used = {1'b0, w_rx_count} + {{(RCW+1){1'b0}}, (r_rx_byte != 2'd0)};
    assign free_out  = (w_rx_used < c_rx_limit);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_byte <= 2'd0;
            r_rx_asm  <= 24'h0;
            r_rx_drop <= 1'b0;
            rx_err    <= 1'b0;
        end else if (r_rx_drop) begin
            if (!put_in) begin
                r_rx_drop <= 1'b0;
            end
        end else if (put_in) begin
            if ((r_rx_byte == 2'd0) && !free_out) begin
                rx_err    <= 1'b1;
                r_rx_drop <= 1'b1;
            end else begin
                r_rx_asm  <= {r_rx_asm[15:0], payload_in};
                r_rx_byte <= r_rx_byte + 2'd1;
            end
        end else if (r_rx_byte != 2'd0) begin
            rx_err    <= 1'b1;
            r_rx_byte <= 2'd0;
        end
    end

    logic w_unused_ok;
    assign w_unused_ok = ^{w_tx_count, w_rx_full};

endmodule
`default_nettype wire

// File: tb/tb_node_link_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_node_link_adapter
// Description : Directed self-checking bench for node_link_adapter
//               (NODEID=0, TX_DEPTH=4, RX_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_node_link_adapter;

    logic        clock;
    logic        reset_n;
    logic [31:0] tx_pkt;
    logic        tx_valid;
    logic        tx_ready;
    logic        free_in;
    logic        put_out;
    logic [7:0]  payload_out;
    logic        put_in;
    logic [7:0]  payload_in;
    logic        free_out;
    logic [31:0] rx_pkt;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_err;
    logic [7:0]  tx_src_mismatch;

    int n_assert = 0;
    int n_fail   = 0;

    node_link_adapter #(.NODEID(0), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .tx_pkt          (tx_pkt),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .free_in         (free_in),
        .put_out         (put_out),
        .payload_out     (payload_out),
        .put_in          (put_in),
        .payload_in      (payload_in),
        .free_out        (free_out),
        .rx_pkt          (rx_pkt),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .rx_err          (rx_err),
        .tx_src_mismatch (tx_src_mismatch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] p, input int i);
        return p[31-8*i -: 8];
    endfunction

    task automatic send_burst(input logic [31:0] p);
        for (int i = 0; i < 4; i++) begin
            put_in     = 1'b1;
            payload_in = byte_of(p, i);
            tick();
        end
        put_in     = 1'b0;
        payload_in = 8'h00;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] p);
        check({tag, "_valid"}, {31'b0, rx_valid}, 32'd1);
        check({tag, "_pkt"}, rx_pkt, p);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    logic [31:0] pa, pb;
    logic [31:0] rxp [4];

    initial begin
        reset_n    = 1'b0;
        tx_pkt     = '0;
        tx_valid   = 1'b0;
        free_in    = 1'b0;
        put_in     = 1'b0;
        payload_in = 8'h00;
        rx_ready   = 1'b0;
        tick();
        tick();

        // ---- reset state
        check("rst_put_out",  {31'b0, put_out},  32'd0);
        check("rst_payload",  {24'b0, payload_out}, 32'd0);
        check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
        check("rst_free_out", {31'b0, free_out}, 32'd1);
        check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        check("rst_rx_pkt",   rx_pkt, 32'd0);
        check("rst_rx_err",   {31'b0, rx_err}, 32'd0);
        check("rst_mismatch", {24'b0, tx_src_mismatch}, 32'd0);
        reset_n = 1'b1;

        // ---- 1: single packet serialised
        free_in  = 1'b1;
        pa       = 32'h13A5_5A01;
        tx_pkt   = pa;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("t1_no_byte_at_push", {31'b0, put_out}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t1_put_b%0d", i), {31'b0, put_out}, 32'd1);
            check($sformatf("t1_pay_b%0d", i), {24'b0, payload_out}, {24'b0, byte_of(pa, i)});
            check($sformatf("t1_ready_b%0d", i), {31'b0, tx_ready}, 32'd1);
        end
        tick();
        check("t1_put_end", {31'b0, put_out}, 32'd0);
        check("t1_mismatch", {24'b0, tx_src_mismatch}, 32'd1);

        // ---- 2a: two packets back-to-back
        pa = 32'h0122_3344;
        pb = 32'h0A0B_0C0D;
        tx_pkt = pa; tx_valid = 1'b1;
        tick();
        tx_pkt = pb;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) tick();
            check($sformatf("t2_put_%0d", i), {31'b0, put_out}, 32'd1);
            check($sformatf("t2_pay_%0d", i), {24'b0, payload_out},
                  {24'b0, (i < 4) ? byte_of(pa, i) : byte_of(pb, i - 4)});
        end
        tick();
        check("t2_put_end", {31'b0, put_out}, 32'd0);

        // ---- 2b: second burst held off by free_in=0
        pa = 32'h0555_6677;
        pb = 32'h0788_99AA;
        tx_pkt = pa; tx_valid = 1'b1;
        tick();
        tx_pkt = pb;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) tick();
            check($sformatf("t2b_pay_%0d", i), {24'b0, payload_out}, {24'b0, byte_of(pa, i)});
        end
        free_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t2b_hold_%0d", i), {31'b0, put_out}, 32'd0);
        end
        free_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t2b_put2_%0d", i), {31'b0, put_out}, 32'd1);
            check($sformatf("t2b_pay2_%0d", i), {24'b0, payload_out}, {24'b0, byte_of(pb, i)});
        end
        tick();
        check("t2b_put_end", {31'b0, put_out}, 32'd0);

        // ---- 3: receive one packet
        put_in = 1'b1; payload_in = 8'h02; tick();
        payload_in = 8'h31; tick();
        payload_in = 8'h00; tick();
        check("t3_not_yet_valid", {31'b0, rx_valid}, 32'd0);
        payload_in = 8'hFF; tick();
        put_in = 1'b0; payload_in = 8'h00;
        check("t3_rx_err", {31'b0, rx_err}, 32'd0);
        pop_check("t3", 32'h0231_00FF);
        check("t3_empty_after_pop", {31'b0, rx_valid}, 32'd0);

        // ---- 4: RX full reservation
        rxp[0] = 32'h1111_2222; rxp[1] = 32'h3333_4444;
        rxp[2] = 32'h5555_6666; rxp[3] = 32'h7777_8888;
        for (int k = 0; k < 3; k++) send_burst(rxp[k]);
        check("t4_free_before_b0", {31'b0, free_out}, 32'd1);
        put_in = 1'b1; payload_in = byte_of(rxp[3], 0);
        tick();
        check("t4_free_after_b0", {31'b0, free_out}, 32'd0);
        for (int i = 1; i < 4; i++) begin
            payload_in = byte_of(rxp[3], i);
            tick();
        end
        put_in = 1'b0; payload_in = 8'h00;
        check("t4_free_full", {31'b0, free_out}, 32'd0);
        pop_check("t4_pop0", rxp[0]);
        check("t4_free_after_pop", {31'b0, free_out}, 32'd1);
        for (int k = 1; k < 4; k++) pop_check($sformatf("t4_pop%0d", k), rxp[k]);
        check("t4_drained", {31'b0, rx_valid}, 32'd0);
        check("t4_rx_err", {31'b0, rx_err}, 32'd0);

        // ---- 5: truncated burst, then a good one
        put_in = 1'b1; payload_in = 8'hAA; tick();
        payload_in = 8'hBB; tick();
        put_in = 1'b0; payload_in = 8'h00;
        tick();
        check("t5_rx_err", {31'b0, rx_err}, 32'd1);
        check("t5_no_valid", {31'b0, rx_valid}, 32'd0);
        check("t5_free_out", {31'b0, free_out}, 32'd1);
        send_burst(32'h0F1E_2D3C);
        pop_check("t5_good", 32'h0F1E_2D3C);

        // ---- 5b: burst arriving while RX is full is ignored entirely
        for (int k = 0; k < 4; k++) send_burst(rxp[k]);
        send_burst(32'hDEAD_BEEF);
        check("t5b_free_out", {31'b0, free_out}, 32'd0);
        for (int k = 0; k < 4; k++) pop_check($sformatf("t5b_pop%0d", k), rxp[k]);
        check("t5b_drained", {31'b0, rx_valid}, 32'd0);
        check("t5b_free_after", {31'b0, free_out}, 32'd1);

        // ---- mismatch counter saturation (src=3 != NODEID)
        tx_pkt = 32'h3000_0000; tx_valid = 1'b1; free_in = 1'b1;
        for (int c = 0; c < 1200; c++) tick();
        tx_valid = 1'b0;
        for (int c = 0; c < 30; c++) tick();
        check("sat_mismatch", {24'b0, tx_src_mismatch}, 32'h0000_00FF);

        // ---- 6: reset during byte1 of a TX burst
        pa = 32'hF1C2_D3E4;
        tx_pkt = pa; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        check("t6_byte1", {24'b0, payload_out}, {24'b0, byte_of(pa, 1)});
        #1 reset_n = 1'b0;
        #1;
        check("t6_put_reset", {31'b0, put_out}, 32'd0);
        check("t6_ready_reset", {31'b0, tx_ready}, 32'd1);
        check("t6_mismatch_reset", {24'b0, tx_src_mismatch}, 32'd0);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("t6_no_residual_%0d", i), {31'b0, put_out}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
